// File: rtl/seq_detector_param.sv
// seq_detector_param
// Programmable Mealy serial-pattern detector. Watches a one-bit serial
// stream and pulses w in the same cycle the final pattern bit arrives.
// The pattern is loadable at runtime. Matching may be overlapping or
// non-overlapping. Input bits are qualified by vld. Matches are counted
// in a saturating counter.
//
// Optional feature macro: SEQDET_STICKY_EN
//   defined   -> a sticky hit flag is built (set by a match, cleared by clr)
//   undefined -> no flag register, hit tied to 0
//
// Parameters:
//   PLEN    - pattern length in bits (2..32)
//   CNTW    - match counter width (1..32)
//   DEF_PAT - pattern loaded at reset
//
// Ports:
//   cl   - clock, rising edge
//   r    - synchronous active-low reset
//   j    - serial data bit
//   vld  - j is valid this cycle; state advances only when set
//   ovl  - 1 = overlapping matches, 0 = non-overlapping
//   load - capture pat into the pattern register (j is discarded)
//   pat  - new pattern, pat[PLEN-1] is received first
//   clr  - clear the match counter and the sticky flag
//   w    - Mealy match pulse
//   cnt  - saturating match count
//   hit  - sticky match flag
module seq_detector_param #(
  parameter int              PLEN    = 5,
  parameter int              CNTW    = 8,
  parameter logic [PLEN-1:0] DEF_PAT = 5'b10110
) (
  input  logic            cl,
  input  logic            r,
  input  logic            j,
  input  logic            vld,
  input  logic            ovl,
  input  logic            load,
  input  logic [PLEN-1:0] pat,
  input  logic            clr,
  output logic            w,
  output logic [CNTW-1:0] cnt,
  output logic            hit
);

  localparam int             FW       = $clog2(PLEN);
  localparam logic [FW-1:0]  FILL_MAX = FW'(PLEN - 1);
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic [PLEN-1:0] pat_q,  pat_d;
  logic [PLEN-2:0] hist_q, hist_d;
  logic [FW-1:0]   fill_q, fill_d;
  logic [CNTW-1:0] cnt_q,  cnt_d;
  logic [PLEN-1:0] histJ;
  logic            m;

  // The window is the held history with the incoming bit appended as the
  // newest (last) pattern bit. Only a full history can match, and a load
  // in the same cycle suppresses the match because j is being discarded.
  always_comb begin
    histJ = {hist_q, j};
    m     = vld & ~load & (fill_q == FILL_MAX) & (histJ == pat_q);
  end

  // The pulse is forced low while reset is held, even if the stale state
  // would otherwise complete a match.
  assign w   = r & m;
  assign cnt = cnt_q;

  // Next-state for pattern, history and counter. A non-overlapping match
  // throws the history away so the next match needs a full fresh pattern;
  // an overlapping match just keeps shifting. The low PLEN-1 bits of the
  // window are the shifted history, which also covers PLEN=2 cleanly.
  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    if (load) begin
      pat_d  = pat;
      hist_d = '0;
      fill_d = '0;
    end else if (vld) begin
      if (m && !ovl) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = histJ[PLEN-2:0];
        if (fill_q != FILL_MAX) begin
          fill_d = fill_q + 1'b1;
        end
      end
    end
    // clr wins over a simultaneous match; the counter never wraps.
    if (clr) begin
      cnt_d = '0;
    end else if (m && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers with synchronous active-low reset; a reset also drops
  // any runtime-loaded pattern back to DEF_PAT.
  always_ff @(posedge cl) begin
    if (!r) begin
      pat_q  <= DEF_PAT;
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
    end
  end

`ifdef SEQDET_STICKY_EN
  logic hit_q, hit_d;

  // Sticky flag: set by any match, cleared by clr (clr wins when both
  // happen in the same cycle).
  always_comb begin
    hit_d = hit_q;
    if (clr) begin
      hit_d = 1'b0;
    end else if (m) begin
      hit_d = 1'b1;
    end
  end

  // Sticky flag register, cleared by reset.
  always_ff @(posedge cl) begin
    if (!r) begin
      hit_q <= 1'b0;
    end else begin
      hit_q <= hit_d;
    end
  end

  assign hit = hit_q;
`else
  assign hit = 1'b0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param
// Directed self-checking bench for seq_detector_param. Two instances share
// all stimulus: one with the default counter width and one with CNTW=2 so
// the saturation behaviour can be seen with a handful of matches.
module tb_seq_detector_param;

  logic       cl;
  logic       r;
  logic       j;
  logic       vld;
  logic       ovl;
  logic       load;
  logic [4:0] pat;
  logic       clr;
  logic       w;
  logic [7:0] cnt;
  logic       hit;
  logic       wSat;
  logic [1:0] cntSat;
  logic       hitSat;

  int checks   = 0;
  int failures = 0;

`ifdef SEQDET_STICKY_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  seq_detector_param #(.PLEN(5), .CNTW(8), .DEF_PAT(5'b10110)) dut (
    .cl(cl), .r(r), .j(j), .vld(vld), .ovl(ovl), .load(load), .pat(pat),
    .clr(clr), .w(w), .cnt(cnt), .hit(hit)
  );

  seq_detector_param #(.PLEN(5), .CNTW(2), .DEF_PAT(5'b10110)) dutSat (
    .cl(cl), .r(r), .j(j), .vld(vld), .ovl(ovl), .load(load), .pat(pat),
    .clr(clr), .w(wSat), .cnt(cntSat), .hit(hitSat)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    cl = 1'b0;
    forever #5 cl = ~cl;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of inputs just after a rising edge, checks the Mealy
  // pulse of both instances on the falling edge, then advances past the
  // next rising edge so registered outputs can be checked afterwards.
  task automatic applyStimulus(input logic rIn, input logic vIn, input logic jIn,
                               input logic loadIn, input logic clrIn,
                               input logic expW, input string tag);
    r    = rIn;
    vld  = vIn;
    j    = jIn;
    load = loadIn;
    clr  = clrIn;
    @(negedge cl);
    checkOutput(tag, {31'b0, w}, {31'b0, expW});
    checkOutput({tag, "_sat"}, {31'b0, wSat}, {31'b0, expW});
    @(posedge cl);
    #1;
    load = 1'b0;
    clr  = 1'b0;
  endtask

  // Feeds n valid bits, MSB of bits first, with the expected pulse for
  // each bit taken from the matching position of expWs.
  task automatic feedBits(input logic [31:0] bits, input int n,
                          input logic [31:0] expWs, input string tag);
    for (int i = n - 1; i >= 0; i--) begin
      applyStimulus(1'b1, 1'b1, bits[i], 1'b0, 1'b0, expWs[i],
                    $sformatf("%s_b%0d", tag, n - i));
    end
  endtask

  // One reset edge with a valid bit present (w must stay low), then the
  // registered outputs must be back at their reset values.
  task automatic doReset(input string tag);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, {tag, "_w"});
    checkOutput({tag, "_cnt"}, {24'b0, cnt}, 32'd0);
    checkOutput({tag, "_hit"}, {31'b0, hit}, 32'd0);
  endtask

  // Directed scenarios with hand-computed expectations.
  initial begin
    r    = 1'b0;
    j    = 1'b0;
    vld  = 1'b0;
    ovl  = 1'b1;
    load = 1'b0;
    pat  = 5'b00000;
    clr  = 1'b0;
    @(posedge cl);
    #1;
    doReset("rst0");

    // Overlapping matching on 1,0,1,1,0,1,1,0: pulses on bits 5 and 8.
    ovl = 1'b1;
    feedBits(32'b10110110, 8, 32'b00001001, "ovl");
    checkOutput("ovl_cnt", {24'b0, cnt}, 32'd2);
    checkOutput("ovl_hit", {31'b0, hit}, {31'b0, STICKY});
    doReset("rst1");

    // Non-overlapping: only bit 5 matches, the trailing 1,1,0 is too short.
    ovl = 1'b0;
    feedBits(32'b10110110, 8, 32'b00001000, "novl");
    checkOutput("novl_cnt", {24'b0, cnt}, 32'd1);
    doReset("rst2");

    // Gap of three invalid cycles between bits 2 and 3 is transparent.
    ovl = 1'b1;
    feedBits(32'b10, 2, 32'b00, "gapA");
    for (int g = 0; g < 3; g++) begin
      applyStimulus(1'b1, 1'b0, g[0], 1'b0, 1'b0, 1'b0, $sformatf("gap_%0d", g));
    end
    feedBits(32'b110, 3, 32'b001, "gapB");
    checkOutput("gap_cnt", {24'b0, cnt}, 32'd1);
    doReset("rst3");

    // Runtime pattern 11111, six ones with overlap: bits 5 and 6 match.
    pat = 5'b11111;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "load");
    feedBits(32'b111111, 6, 32'b000011, "ones");
    checkOutput("ones_cnt", {24'b0, cnt}, 32'd2);
    // History is full of ones: a load with a valid 1 must not match and
    // must restart filling, so four more ones do nothing and the fifth hits.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "load_mid");
    checkOutput("load_mid_cnt", {24'b0, cnt}, 32'd2);
    feedBits(32'b11111, 5, 32'b00001, "refill");
    checkOutput("refill_cnt", {24'b0, cnt}, 32'd3);
    doReset("rst4");

    // Saturation: pattern 11111, nine ones give five overlapping matches.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "load2");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, (i >= 4), $sformatf("sat_b%0d", i + 1));
      if (i >= 4) begin
        checkOutput($sformatf("sat_cnt_%0d", i - 3), {30'b0, cntSat},
                    ((i - 3) > 3) ? 32'd3 : 32'(i - 3));
        checkOutput($sformatf("wide_cnt_%0d", i - 3), {24'b0, cnt}, 32'(i - 3));
      end
    end
    checkOutput("sat_hit", {31'b0, hitSat}, {31'b0, STICKY});
    // clr in the same cycle as a match: counters and flag end up cleared.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "clr_match");
    checkOutput("clr_cnt", {24'b0, cnt}, 32'd0);
    checkOutput("clr_cnt_sat", {30'b0, cntSat}, 32'd0);
    checkOutput("clr_hit", {31'b0, hit}, 32'd0);
    checkOutput("clr_hit_sat", {31'b0, hitSat}, 32'd0);

    // Reset mid-pattern after a runtime load: pattern reverts to 10110.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "load3");
    feedBits(32'b1011, 4, 32'b0000, "pre");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "rst_mid");
    feedBits(32'b10110, 5, 32'b00001, "revert");
    checkOutput("revert_cnt", {24'b0, cnt}, 32'd1);

    // Default pattern, 1,0,1,1 then a 0 arriving during reset: the match
    // is masked, and the following 0 finds an empty history.
    feedBits(32'b1011, 4, 32'b0000, "pre2");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "rst_forced");
    checkOutput("rst_forced_cnt", {24'b0, cnt}, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
